uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame sequencing FSM that drives strobes to an
// external shift register / output register and manages byte handshaking.
module uart_rx_ctrl #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ready,
    output logic       shift_en,
    output logic       load_en,
    output logic [3:0] bit_count,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W  = $clog2(BAUD_DIV);
    localparam int DCNT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(BAUD_DIV - 1);
    localparam logic [DCNT_W-1:0] LAST_BIT  = DCNT_W'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_CNT  = 4'(DATA_BITS + 2);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  baud_cnt_reg, baud_cnt_next;
    logic [DCNT_W-1:0] data_cnt_reg, data_cnt_next;
    logic              rx_valid_reg, rx_valid_next;

    logic baud_done;
    logic half_done;
    logic shift_raw;
    logic load_raw;
    logic ferr_raw;
    logic overrun_raw;
    logic accept;
    logic busy_raw;
    logic [3:0] bit_count_raw;

    assign baud_done = (baud_cnt_reg == FULL_M1);
    assign half_done = (baud_cnt_reg == HALF_M1);

    // Strobes are pure decodes of registered state so they align with the
    // sample point without an extra cycle of latency.
    assign shift_raw   = (state_reg == ST_DATA) && baud_done;
    assign load_raw    = (state_reg == ST_STOP) && baud_done && rx;
    assign ferr_raw    = (state_reg == ST_STOP) && baud_done && !rx;
    assign accept      = rx_valid_reg && rx_ready;
    assign overrun_raw = load_raw && rx_valid_reg && !rx_ready;

    always_comb begin
        state_next    = state_reg;
        data_cnt_next = data_cnt_reg;
        // Saturating count keeps the idle/break counters from wrapping.
        baud_cnt_next = baud_done ? baud_cnt_reg : baud_cnt_reg + 1'b1;

        case (state_reg)
            ST_IDLE: begin
                data_cnt_next = '0;
                if (!rx) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (half_done) begin
                    state_next = rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    data_cnt_next = data_cnt_reg + 1'b1;
                    baud_cnt_next = '0;
                    if (data_cnt_reg == LAST_BIT) begin
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    state_next = rx ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next != state_reg) begin
            baud_cnt_next = '0;
        end
    end

    // A fresh load always wins over a simultaneous acceptance.
    always_comb begin
        rx_valid_next = rx_valid_reg;
        if (load_raw) begin
            rx_valid_next = 1'b1;
        end else if (accept) begin
            rx_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            data_cnt_reg <= '0;
            rx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            data_cnt_reg <= data_cnt_next;
            rx_valid_reg <= rx_valid_next;
        end
    end

    always_comb begin
        bit_count_raw = 4'd0;
        busy_raw      = 1'b0;
        case (state_reg)
            ST_START: begin
                bit_count_raw = 4'd1;
                busy_raw      = 1'b1;
            end
            ST_DATA: begin
                bit_count_raw = 4'(data_cnt_reg) + 4'd2;
                busy_raw      = 1'b1;
            end
            ST_STOP: begin
                bit_count_raw = STOP_CNT;
                busy_raw      = 1'b1;
            end
            default: begin
                bit_count_raw = 4'd0;
                busy_raw      = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is held so an abandoned frame
    // can never emit a strobe in the reset cycle.
    assign shift_en  = shift_raw && !reset;
    assign load_en   = load_raw && !reset;
    assign frame_err = ferr_raw && !reset;
    assign overrun   = overrun_raw && !reset;
    assign rx_valid  = rx_valid_reg && !reset;
    assign busy      = busy_raw && !reset;
    assign bit_count = reset ? 4'd0 : bit_count_raw;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl with BAUD_DIV=8, DATA_BITS=8.
module tb_uart_rx_ctrl;

    localparam int BD = 8;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic       shift_en;
    logic       load_en;
    logic [3:0] bit_count;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_ctrl #(.BAUD_DIV(BD), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .shift_en  (shift_en),
        .load_en   (load_en),
        .bit_count (bit_count),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_load;
        logic [7:0] data;
        bit         ovr;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   held  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_shift_en"},  32'(shift_en),  0);
        check({tag, "_load_en"},   32'(load_en),   0);
        check({tag, "_bit_count"}, 32'(bit_count), 0);
        check({tag, "_rx_valid"},  32'(rx_valid),  0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_frame_err"}, 32'(frame_err), 0);
        check({tag, "_overrun"},   32'(overrun),   0);
    endtask

    // Frame cycle c: start bit 0..7, data bit i at 8+8i..15+8i, stop bit 72..79.
    // Expected observables follow from the mid-bit sample points of the protocol.
    task automatic send_frame(input logic [7:0] data, input bit stop, input bit rdy_load,
                              input int abort_at, input int extra_low);
        int bi;
        int exp_bc;
        bit hb;
        hb = held;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                reset = 1'b1;
                rx = 1'b1;
                rx_ready = 1'b0;
                #1;
                check_all_zero("in_reset");
                @(negedge clk);
                reset = 1'b0;
                #1;
                check_all_zero("after_reset");
                held = 1'b0;
                $display("frame %02h aborted by reset at cycle %0d", data, c);
                return;
            end
            bi = c / BD;
            rx = (bi == 0) ? 1'b0 : (bi <= DB) ? data[bi-1] : stop;
            rx_ready = rdy_load && (c == 76);
            if (c == 0 && abort_at < 0) begin
                exp_q.push_back('{is_load: stop, data: data,
                                  ovr: stop && hb && !rdy_load, at: cyc + 76});
            end
            #1;
            if (c == 0) exp_bc = 0;
            else if (c <= 4) exp_bc = 1;
            else if (c <= 68) exp_bc = 2 + (c - 5) / BD;
            else if (c <= 76) exp_bc = DB + 2;
            else exp_bc = 0;
            check("busy", 32'(busy), 32'(c >= 1 && c <= 76));
            check("bit_count", 32'(bit_count), 32'(exp_bc));
            check("rx_valid", 32'(rx_valid), 32'((stop && c >= 77) ? 1'b1 : hb));
        end
        if (stop) held = 1'b1;
        for (int i = 0; i < extra_low; i++) begin
            @(negedge clk);
            rx = 1'b0;
            rx_ready = 1'b0;
            #1;
            check("break_busy", 32'(busy), 0);
            check("break_bit_count", 32'(bit_count), 0);
        end
        $display("frame %02h stop=%0d ready_at_load=%0d extra_low=%0d sent", data, stop, rdy_load, extra_low);
    endtask

    task automatic glitch();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rx = (c < 2) ? 1'b0 : 1'b1;
            rx_ready = 1'b0;
            #1;
            check("glitch_busy", 32'(busy), 32'(c >= 1 && c <= 4));
            check("glitch_bit_count", 32'(bit_count), 32'((c >= 1 && c <= 4) ? 1 : 0));
            check("glitch_shift_en", 32'(shift_en), 0);
            check("glitch_rx_valid", 32'(rx_valid), 32'(held));
        end
        $display("glitch sent");
    endtask

    task automatic gap(input int n, input bit pulse);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
            rx_ready = pulse && (i == 0);
            #1;
            check("gap_busy", 32'(busy), 0);
            check("gap_bit_count", 32'(bit_count), 0);
            if (pulse && i == 0) check("pre_accept_rx_valid", 32'(rx_valid), 32'(held));
            if (pulse && i == 1) check("post_accept_rx_valid", 32'(rx_valid), 0);
        end
        if (pulse) held = 1'b0;
    endtask

    // Monitor: rebuilds the byte the external shift register would capture
    // and scores every load_en / frame_err against the expectation queue.
    initial begin
        logic [7:0] sreg;
        int nshift;
        exp_t e;
        sreg = '0;
        nshift = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                nshift = 0;
            end else begin
                if (shift_en) begin
                    sreg = {rx, sreg[7:1]};
                    nshift++;
                end
                if (load_en || frame_err) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_event: load_en=%0d frame_err=%0d, expected none (cycle %0d)",
                                 load_en, frame_err, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_load", 32'(load_en), 32'(e.is_load));
                        check("event_kind_ferr", 32'(frame_err), 32'(!e.is_load));
                        check("event_cycle", 32'(cyc), 32'(e.at));
                        check("shift_count", 32'(nshift), 32'(DB));
                        check("overrun", 32'(overrun), 32'(e.ovr));
                        if (e.is_load) check("data", 32'(sreg), 32'(e.data));
                        $display("event at cycle %0d: load=%0d ferr=%0d data=%02h overrun=%0d",
                                 cyc, load_en, frame_err, sreg, overrun);
                    end
                    nshift = 0;
                end else if (overrun) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_overrun: got 1, expected 0 (cycle %0d)", cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit p;
        reset = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_all_zero("reset");
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("post_reset");
        gap(3, 1'b0);

        send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
        gap(2, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b0, -1, 0);
        gap(3, 1'b1);
        send_frame(8'($urandom), 1'b1, 1'b0, -1, 0);
        gap(2, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b1, -1, 0);
        gap(3, 1'b1);
        glitch();
        gap(2, 1'b0);
        send_frame(8'($urandom), 1'b0, 1'b0, -1, 20);
        gap(1, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b0, -1, 0);
        gap(2, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b0, 30, 0);
        gap(2, 1'b0);
        send_frame(8'($urandom), 1'b1, 1'b0, -1, 0);
        gap(3, 1'b1);

        for (int k = 0; k < 24; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch();
            end else begin
                send_frame(8'($urandom), r != 1, (r > 1) && ($urandom_range(0, 3) == 0), -1,
                           (r == 1) ? int'($urandom_range(0, 12)) : 0);
            end
            p = ($urandom_range(0, 2) == 0);
            gap(p ? int'($urandom_range(2, 5)) : int'($urandom_range(1, 5)), p);
        end

        repeat (5) @(negedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
